// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit seven-segment scan driver with hex glyphs, decimal points,
// leading-zero blanking and frame-synchronous display updates.
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int HEX_MODE    = 1,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    frame_done,
  output logic                    update_pending
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [4*NUM_DIGITS-1:0] disp_val_q, disp_val_d;
  logic [NUM_DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic                    upd_pend_q, upd_pend_d;
  logic                    frame_done_q, frame_done_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   sel_q, sel_d;

  logic                    boundary;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    hi_zero;
  logic                    blank;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b0111111;
      4'h1: g = 7'b0000110;
      4'h2: g = 7'b1011011;
      4'h3: g = 7'b1001111;
      4'h4: g = 7'b1100110;
      4'h5: g = 7'b1101101;
      4'h6: g = 7'b1111101;
      4'h7: g = 7'b0000111;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1101111;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b1111100;
      4'hC: g = 7'b0111001;
      4'hD: g = 7'b1011110;
      4'hE: g = 7'b1111001;
      default: g = 7'b1110001;
    endcase
    if (HEX_MODE == 0 && nib > 4'd9) g = 7'b0000000;
    return g;
  endfunction

  always_comb begin
    div_cnt_d    = div_cnt_q;
    idx_d        = idx_q;
    pend_val_d   = pend_val_q;
    pend_dp_d    = pend_dp_q;
    disp_val_d   = disp_val_q;
    disp_dp_d    = disp_dp_q;
    upd_pend_d   = upd_pend_q;
    seg_d        = 7'b0000000;
    dp_d         = 1'b0;
    sel_d        = '0;
    cur_nib      = 4'h0;
    cur_dp       = 1'b0;
    hi_zero      = 1'b1;

    boundary     = enable && (div_cnt_q == CNT_LAST) && (idx_q == IDX_LAST);
    frame_done_d = boundary;

    if (enable) begin
      if (div_cnt_q == CNT_LAST) begin
        div_cnt_d = '0;
        idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
      end else begin
        div_cnt_d = div_cnt_q + CNT_W'(1);
      end
    end

    // A load landing on the boundary bypasses pending so the new frame shows it at once.
    if (load) begin
      pend_val_d = value_in;
      pend_dp_d  = dp_in;
    end
    if (boundary && load) begin
      disp_val_d = value_in;
      disp_dp_d  = dp_in;
      upd_pend_d = 1'b0;
    end else if (boundary && upd_pend_q) begin
      disp_val_d = pend_val_q;
      disp_dp_d  = pend_dp_q;
      upd_pend_d = 1'b0;
    end else if (load) begin
      upd_pend_d = 1'b1;
    end

    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (idx_q == IDX_W'(j)) begin
        cur_nib = disp_val_q[4*j +: 4];
        cur_dp  = disp_dp_q[j];
      end
      if (j >= int'(idx_q) && disp_val_q[4*j +: 4] != 4'h0) hi_zero = 1'b0;
    end
    blank = blank_lz && (idx_q != '0) && hi_zero;

    if (enable) begin
      sel_d = NUM_DIGITS'(1) << idx_q;
      seg_d = blank ? 7'b0000000 : glyph(cur_nib);
      dp_d  = cur_dp;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      disp_val_q   <= '0;
      disp_dp_q    <= '0;
      upd_pend_q   <= 1'b0;
      frame_done_q <= 1'b0;
      seg_q        <= 7'b0000000;
      dp_q         <= 1'b0;
      sel_q        <= '0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      pend_val_q   <= pend_val_d;
      pend_dp_q    <= pend_dp_d;
      disp_val_q   <= disp_val_d;
      disp_dp_q    <= disp_dp_d;
      upd_pend_q   <= upd_pend_d;
      frame_done_q <= frame_done_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      sel_q        <= sel_d;
    end
  end

  // Polarity applied after the flops so internal state is always active-high.
  assign seg            = (ACTIVE_LOW != 0) ? ~seg_q : seg_q;
  assign dp             = (ACTIVE_LOW != 0) ? ~dp_q  : dp_q;
  assign digit_sel      = (ACTIVE_LOW != 0) ? ~sel_q : sel_q;
  assign frame_done     = frame_done_q;
  assign update_pending = upd_pend_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: two builds (hex/active-high and decimal/active-low)
// against a frame-position reference model, directed scenarios then random traffic.
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int RD    = 4;
  localparam int FRAME = N * RD;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [15:0]   value_in;
  logic [3:0]    dp_in;
  logic          load;
  logic          blank_lz;

  logic [6:0]    seg_a, seg_b;
  logic          dp_a, dp_b;
  logic [3:0]    sel_a, sel_b;
  logic          fd_a, fd_b;
  logic          up_a, up_b;

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .HEX_MODE(1), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .reset(reset), .enable(enable), .value_in(value_in), .dp_in(dp_in),
    .load(load), .blank_lz(blank_lz), .seg(seg_a), .dp(dp_a), .digit_sel(sel_a),
    .frame_done(fd_a), .update_pending(up_a));

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .HEX_MODE(0), .ACTIVE_LOW(1)) dut_b (
    .clk(clk), .reset(reset), .enable(enable), .value_in(value_in), .dp_in(dp_in),
    .load(load), .blank_lz(blank_lz), .seg(seg_b), .dp(dp_b), .digit_sel(sel_b),
    .frame_done(fd_b), .update_pending(up_b));

  always #5 clk = ~clk;

  int checks = 0;
  int miscompares = 0;

  // Reference model: position in the scan is just a count of enabled cycles.
  int          t;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_ddp, m_pdp;
  logic        m_upd;
  logic [6:0]  e_seg_h, e_seg_n;
  logic        e_dp;
  logic [3:0]  e_sel;
  logic        e_fd;

  logic [6:0] glyph_tab [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};

  function automatic logic [6:0] ref_glyph(input logic [3:0] nib, input bit hex);
    if (nib > 4'd9 && !hex) return 7'b0000000;
    return glyph_tab[nib];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic check_all();
    logic [6:0] inv_seg;
    logic       inv_dp;
    logic [3:0] inv_sel;
    inv_seg = ~e_seg_n;
    inv_dp  = ~e_dp;
    inv_sel = ~e_sel;
    chk("seg_a", 32'(seg_a), 32'(e_seg_h));
    chk("dp_a", 32'(dp_a), 32'(e_dp));
    chk("sel_a", 32'(sel_a), 32'(e_sel));
    chk("frame_done_a", 32'(fd_a), 32'(e_fd));
    chk("upd_pend_a", 32'(up_a), 32'(m_upd));
    chk("seg_b", 32'(seg_b), 32'(inv_seg));
    chk("dp_b", 32'(dp_b), 32'(inv_dp));
    chk("sel_b", 32'(sel_b), 32'(inv_sel));
    chk("frame_done_b", 32'(fd_b), 32'(e_fd));
    chk("upd_pend_b", 32'(up_b), 32'(m_upd));
  endtask

  task automatic model_reset();
    t = 0; m_disp = '0; m_pend = '0; m_ddp = '0; m_pdp = '0; m_upd = 1'b0;
    e_seg_h = '0; e_seg_n = '0; e_dp = 1'b0; e_sel = '0; e_fd = 1'b0;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step();
    int         dg;
    bit         bnd;
    logic [3:0] nib;
    dg  = (t / RD) % N;
    bnd = enable && ((t % FRAME) == FRAME - 1);
    e_seg_h = '0; e_seg_n = '0; e_dp = 1'b0; e_sel = '0;
    if (enable) begin
      e_sel = 4'(1 << dg);
      e_dp  = m_ddp[dg];
      nib   = 4'(m_disp >> (4 * dg));
      if (!(blank_lz && dg > 0 && (m_disp >> (4 * dg)) == 16'h0)) begin
        e_seg_h = ref_glyph(nib, 1'b1);
        e_seg_n = ref_glyph(nib, 1'b0);
      end
    end
    e_fd = bnd;
    if (bnd && load) begin
      m_disp = value_in; m_ddp = dp_in; m_upd = 1'b0;
    end else begin
      if (bnd && m_upd) begin
        m_disp = m_pend; m_ddp = m_pdp; m_upd = 1'b0;
      end
      if (load) begin
        m_pend = value_in; m_pdp = dp_in; m_upd = 1'b1;
      end
    end
    if (enable) t++;
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic run_to(input int pos);
    for (int k = 0; k < FRAME && (t % FRAME) != pos; k++) step();
  endtask

  task automatic load_val(input logic [15:0] v, input logic [3:0] d);
    value_in = v; dp_in = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; load = 1'b0; blank_lz = 1'b0;
    value_in = '0; dp_in = '0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    enable = 1'b1;

    // Basic scan of 1234
    load_val(16'h1234, 4'b0000);
    run(40 + FRAME);

    // Hex glyph with leading-zero blanking
    blank_lz = 1'b1;
    load_val(16'h00A0, 4'b0000);
    run(2 * FRAME);
    blank_lz = 1'b0;
    run(FRAME);

    // Load mid-frame waits for the boundary
    run_to(RD + 1);
    load_val(16'h5678, 4'b0100);
    run(2 * FRAME);

    // Last load wins, then a load coincident with the boundary
    load_val(16'h1111, 4'b0000);
    run(3);
    load_val(16'h2222, 4'b0010);
    run(2 * FRAME);
    run_to(FRAME - 1);
    load_val(16'h9ABC, 4'b1000);
    run(FRAME);

    // Enable dropped mid-digit, with a load while dark
    run_to(2 * RD + 1);
    enable = 1'b0;
    run(4);
    load_val(16'hDEF0, 4'b0001);
    run(5);
    enable = 1'b1;
    run(2 * FRAME + 4);

    // Reset with an update pending, then decimal points
    run_to(RD + 2);
    load_val(16'h4321, 4'b1111);
    run(2);
    do_reset();
    enable = 1'b1;
    run(FRAME);
    load_val(16'h0007, 4'b0001);
    blank_lz = 1'b1;
    run(3 * FRAME);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      enable   = ($urandom_range(0, 15) != 0);
      load     = ($urandom_range(0, 9) == 0);
      blank_lz = ($urandom_range(0, 1) == 1);
      value_in = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      dp_in    = 4'($urandom);
      step();
      load = 1'b0;
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", checks, miscompares);
    $finish;
  end

endmodule
